// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port 1024x32 memory between the
// data port (m0) and the instruction-fetch port (m1). m0 has fixed priority;
// an aging counter lets m1 override after MAX_WAIT consecutive denied cycles.
// Read data returns one cycle after grant, routed back to the granted port.
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_wen,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wen,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  input  logic [31:0] mem_q
);

  typedef enum logic {
    SEL_M0 = 1'b0,
    SEL_M1 = 1'b1
  } sel_e;

  localparam logic [WAIT_W-1:0] LP_MAX_WAIT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] r_wait_cnt;
  sel_e              r_rsel;
  logic              r_rvalid;

  logic              w_aged;
  logic              w_m0_win;
  logic              w_m1_win;
  logic [WAIT_W-1:0] w_wait_nxt;

  // Winner selection; all grants are suppressed while reset is held.
  always_comb begin
    w_aged   = (r_wait_cnt == LP_MAX_WAIT);
    w_m1_win = 1'b0;
    w_m0_win = 1'b0;
    if (!rst) begin
      w_m1_win = m1_req && (!m0_req || w_aged);
      w_m0_win = m0_req && !w_m1_win;
    end
  end

  // Drive the memory command from the winner, zeros when idle.
  always_comb begin
    m0_gnt  = w_m0_win;
    m1_gnt  = w_m1_win;
    mem_cen = 1'b0;
    mem_wen = 1'b0;
    mem_a   = '0;
    mem_d   = '0;
    if (w_m1_win) begin
      mem_cen = 1'b1;
      mem_wen = m1_wen;
      mem_a   = m1_addr;
      mem_d   = m1_wdata;
    end else if (w_m0_win) begin
      mem_cen = 1'b1;
      mem_wen = m0_wen;
      mem_a   = m0_addr;
      mem_d   = m0_wdata;
    end
  end

  // Aging counter next value: cleared on m1 grant or when m1 is idle,
  // otherwise counts denied cycles up to MAX_WAIT.
  always_comb begin
    w_wait_nxt = '0;
    if (m1_req && !w_m1_win) begin
      if (r_wait_cnt == LP_MAX_WAIT) begin
        w_wait_nxt = r_wait_cnt;
      end else begin
        w_wait_nxt = r_wait_cnt + 1'b1;
      end
    end
  end

  // Aging state and response pipeline; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_rsel     <= SEL_M0;
      r_rvalid   <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
      r_rvalid   <= mem_cen & ~mem_wen;
      r_rsel     <= w_m1_win ? SEL_M1 : SEL_M0;
    end
  end

  // Route the memory read data to the port that was granted last cycle.
  always_comb begin
    m0_rvalid = r_rvalid && (r_rsel == SEL_M0);
    m1_rvalid = r_rvalid && (r_rsel == SEL_M1);
    m0_rdata  = '0;
    m1_rdata  = '0;
    if (!rst) begin
      if (r_rsel == SEL_M1) begin
        m1_rdata = mem_q;
      end else begin
        m0_rdata = mem_q;
      end
    end
  end

endmodule
